// File: rtl/updown_counter_core.sv
// Loadable up/down counter with wrap/saturate, run FSM, prescaler, tc and sticky ovf.
// Optional capture register enabled by defining COUNTER_CAPTURE_EN.
module updown_counter_core #(
    parameter int WIDTH    = 4,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             up_dn,
    input  logic             sat_mode,
    input  logic             clr_ovf,
    input  logic             capture,
    output logic [WIDTH-1:0] count,
    output logic             running,
    output logic             tc,
    output logic             ovf,
    output logic [WIDTH-1:0] cap_val,
    output logic             cap_valid
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
    localparam logic [WIDTH-1:0] MAX = {WIDTH{1'b1}};

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    pre_q, pre_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;
    logic             step_tick;
    logic             step;
    logic             at_bound;

    // Next-state: stop has priority over start; load never alters state
    always_comb begin
        state_d = state_q;
        if (stop) begin
            state_d = S_IDLE;
        end else if (start) begin
            state_d = S_RUN;
        end
    end

    // Prescaler advances only in RUN; cleared on load and when leaving RUN
    always_comb begin
        step_tick = (state_q == S_RUN) && (pre_q == PRE_LAST);
        pre_d     = pre_q;
        if (state_q != S_RUN || state_d != S_RUN || load) begin
            pre_d = '0;
        end else if (step_tick) begin
            pre_d = '0;
        end else begin
            pre_d = pre_q + 1'b1;
        end
    end

    // Count update: load beats step; boundary steps wrap or hold and flag tc/ovf
    always_comb begin
        step     = step_tick && !load;
        at_bound = up_dn ? (count_q == MAX) : (count_q == '0);
        count_d  = count_q;
        tc_d     = 1'b0;
        ovf_d    = clr_ovf ? 1'b0 : ovf_q;
        if (load) begin
            count_d = load_val;
        end else if (step) begin
            if (at_bound) begin
                tc_d  = 1'b1;
                ovf_d = 1'b1;
                if (!sat_mode) begin
                    count_d = up_dn ? '0 : MAX;
                end
            end else begin
                count_d = up_dn ? count_q + 1'b1 : count_q - 1'b1;
            end
        end
    end

    // Core state registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pre_q   <= '0;
            count_q <= '0;
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            count_q <= count_d;
            tc_q    <= tc_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count   = count_q;
    assign running = (state_q == S_RUN);
    assign tc      = tc_q;
    assign ovf     = ovf_q;

`ifdef COUNTER_CAPTURE_EN
    logic [WIDTH-1:0] cap_val_q, cap_val_d;
    logic             cap_valid_q, cap_valid_d;

    // Snapshot the pre-update count on request
    always_comb begin
        cap_val_d   = capture ? count_q : cap_val_q;
        cap_valid_d = capture;
    end

    // Capture registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cap_val_q   <= '0;
            cap_valid_q <= 1'b0;
        end else begin
            cap_val_q   <= cap_val_d;
            cap_valid_q <= cap_valid_d;
        end
    end

    assign cap_val   = cap_val_q;
    assign cap_valid = cap_valid_q;
`else
    logic unused_capture;
    assign unused_capture = capture;
    assign cap_val        = '0;
    assign cap_valid      = 1'b0;
`endif

endmodule

// File: tb/tb_updown_counter_core.sv
// Directed bench for updown_counter_core.
// Two instances: PRESCALE=1 (table) and PRESCALE=3 (prescaler sequence).
module tb_updown_counter_core;

    logic       clk = 1'b0;
    logic       rst_n, start, stop, load, up_dn, sat_mode, clr_ovf, capture;
    logic [3:0] load_val;
    logic [3:0] count, cap_val, count3, cap_val3;
    logic       running, tc, ovf, cap_valid;
    logic       running3, tc3, ovf3, cap_valid3;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    updown_counter_core #(.WIDTH(4), .PRESCALE(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .load(load), .load_val(load_val), .up_dn(up_dn),
        .sat_mode(sat_mode), .clr_ovf(clr_ovf), .capture(capture),
        .count(count), .running(running), .tc(tc), .ovf(ovf),
        .cap_val(cap_val), .cap_valid(cap_valid)
    );

    updown_counter_core #(.WIDTH(4), .PRESCALE(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .load(load), .load_val(load_val), .up_dn(up_dn),
        .sat_mode(sat_mode), .clr_ovf(clr_ovf), .capture(capture),
        .count(count3), .running(running3), .tc(tc3), .ovf(ovf3),
        .cap_val(cap_val3), .cap_valid(cap_valid3)
    );

    typedef struct {
        logic       rst_n, start, stop, load;
        logic [3:0] lv;
        logic       up, sat, clr;
        logic [3:0] cnt;
        logic       run, tc, ovf;
    } vec_t;

    vec_t tbl[33];

    task automatic chk(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d]: got %0h want %0h", name, idx, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in;
        rst_n = 1'b1; start = 1'b0; stop = 1'b0; load = 1'b0;
        load_val = 4'h0; up_dn = 1'b1; sat_mode = 1'b0;
        clr_ovf = 1'b0; capture = 1'b0;
    endtask

    initial begin
        logic [3:0] exp_cv;
        logic       exp_cvld;
        tbl[0]  = '{0,0,0,0,4'h0,1,0,0, 4'h0,0,0,0};
        tbl[1]  = '{0,0,0,0,4'h0,1,0,0, 4'h0,0,0,0};
        tbl[2]  = '{1,0,0,1,4'hE,1,0,0, 4'hE,0,0,0};
        tbl[3]  = '{1,1,0,0,4'h0,1,0,0, 4'hE,1,0,0};
        tbl[4]  = '{1,0,0,0,4'h0,1,0,0, 4'hF,1,0,0};
        tbl[5]  = '{1,0,0,0,4'h0,1,0,0, 4'h0,1,1,1};
        tbl[6]  = '{1,0,0,0,4'h0,1,0,0, 4'h1,1,0,1};
        tbl[7]  = '{1,0,1,0,4'h0,1,0,0, 4'h2,0,0,1};
        tbl[8]  = '{1,0,0,0,4'h0,1,0,0, 4'h2,0,0,1};
        tbl[9]  = '{1,0,0,0,4'h0,1,0,1, 4'h2,0,0,0};
        tbl[10] = '{1,0,0,1,4'h1,0,1,0, 4'h1,0,0,0};
        tbl[11] = '{1,1,0,0,4'h0,0,1,0, 4'h1,1,0,0};
        tbl[12] = '{1,0,0,0,4'h0,0,1,0, 4'h0,1,0,0};
        tbl[13] = '{1,0,0,0,4'h0,0,1,0, 4'h0,1,1,1};
        tbl[14] = '{1,0,0,0,4'h0,0,1,1, 4'h0,1,1,1};
        tbl[15] = '{1,0,1,0,4'h0,0,1,0, 4'h0,0,1,1};
        tbl[16] = '{1,0,0,0,4'h0,0,1,1, 4'h0,0,0,0};
        tbl[17] = '{1,1,0,0,4'h0,0,0,0, 4'h0,1,0,0};
        tbl[18] = '{1,0,0,0,4'h0,0,0,0, 4'hF,1,1,1};
        tbl[19] = '{1,0,0,0,4'h0,0,0,0, 4'hE,1,0,1};
        tbl[20] = '{1,0,0,1,4'hF,1,1,0, 4'hF,1,0,1};
        tbl[21] = '{1,0,0,0,4'h0,1,1,0, 4'hF,1,1,1};
        tbl[22] = '{1,0,1,0,4'h0,1,1,0, 4'hF,0,1,1};
        tbl[23] = '{1,1,1,0,4'h0,1,1,0, 4'hF,0,0,1};
        tbl[24] = '{1,1,1,0,4'h0,1,1,0, 4'hF,0,0,1};
        tbl[25] = '{1,1,0,0,4'h0,1,0,0, 4'hF,1,0,1};
        tbl[26] = '{1,0,0,0,4'h0,1,0,0, 4'h0,1,1,1};
        tbl[27] = '{1,0,0,1,4'h7,1,0,0, 4'h7,1,0,1};
        tbl[28] = '{1,0,0,0,4'h0,1,0,0, 4'h8,1,0,1};
        tbl[29] = '{0,0,0,0,4'h0,1,0,0, 4'h0,0,0,0};
        tbl[30] = '{0,0,0,0,4'h0,1,0,0, 4'h0,0,0,0};
        tbl[31] = '{1,1,0,1,4'hA,1,0,0, 4'hA,1,0,0};
        tbl[32] = '{1,0,0,0,4'h0,1,0,0, 4'hB,1,0,0};

        idle_in();
        for (int i = 0; i < 33; i++) begin
            rst_n    = tbl[i].rst_n;
            start    = tbl[i].start;
            stop     = tbl[i].stop;
            load     = tbl[i].load;
            load_val = tbl[i].lv;
            up_dn    = tbl[i].up;
            sat_mode = tbl[i].sat;
            clr_ovf  = tbl[i].clr;
            tick();
            chk("count", i, 32'(count), 32'(tbl[i].cnt));
            chk("running", i, 32'(running), 32'(tbl[i].run));
            chk("tc", i, 32'(tc), 32'(tbl[i].tc));
            chk("ovf", i, 32'(ovf), 32'(tbl[i].ovf));
            chk("cap_valid", i, 32'(cap_valid), 32'd0);
        end

        // capture while stepping
        idle_in();
        load = 1'b1; load_val = 4'h5;
        tick();
        chk("cap_load_cnt", 0, 32'(count), 32'h5);
        idle_in();
        capture = 1'b1;
        tick();
`ifdef COUNTER_CAPTURE_EN
        exp_cv = 4'h5; exp_cvld = 1'b1;
`else
        exp_cv = 4'h0; exp_cvld = 1'b0;
`endif
        chk("cap_step_cnt", 0, 32'(count), 32'h6);
        chk("cap_val", 0, 32'(cap_val), 32'(exp_cv));
        chk("cap_valid_p", 0, 32'(cap_valid), 32'(exp_cvld));
        idle_in();
        tick();
        chk("cap_after_cnt", 0, 32'(count), 32'h7);
        chk("cap_valid_0", 0, 32'(cap_valid), 32'd0);
        chk("cap_val_hold", 0, 32'(cap_val), 32'(exp_cv));

        // prescaler = 3 sequence
        idle_in();
        rst_n = 1'b0;
        tick();
        chk("p3_rst_cnt", 0, 32'(count3), 32'h0);
        idle_in();
        start = 1'b1;
        tick();
        chk("p3_run", 0, 32'(running3), 32'd1);
        idle_in();
        for (int c = 1; c <= 7; c++) begin
            tick();
            chk("p3_cnt", c, 32'(count3), 32'(c / 3));
        end
        stop = 1'b1;
        tick();
        chk("p3_stop_run", 0, 32'(running3), 32'd0);
        chk("p3_stop_cnt", 0, 32'(count3), 32'h2);
        idle_in();
        tick();
        chk("p3_idle_cnt", 0, 32'(count3), 32'h2);
        start = 1'b1;
        tick();
        chk("p3_restart", 0, 32'(running3), 32'd1);
        idle_in();
        for (int c = 1; c <= 3; c++) begin
            tick();
            chk("p3_re_cnt", c, 32'(count3), (c == 3) ? 32'h3 : 32'h2);
        end
        chk("p3_tc", 0, 32'(tc3), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
